// File: rtl/forward_unit.sv
// forward_unit: load-use hazard detection and EX operand-forward select generation.
// Tracks EX/MEM/WB producer entries and compares them against the ID sources.
// Define FORWARD_UNIT_BYPASS_EN to enable EX/MEM forwarding; when it is not defined
// there is no bypass network, selects stay 00 and any EX/MEM producer match stalls.
module forward_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  load;
    logic [REG_ADDR_W-1:0] dst;
  } entry_t;

  entry_t ex_q, mem_q, wb_q;
  entry_t id_entry;

  logic ex_src, mem_src;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic hazard;
  logic bubble;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // Producer qualification and source-address matches against EX and MEM
  always_comb begin
    ex_src  = ex_q.valid  & ex_q.wr  & (ex_q.dst  != '0);
    mem_src = mem_q.valid & mem_q.wr & (mem_q.dst != '0);
    rs_ex   = id_use_rs & ex_src  & (id_rs == ex_q.dst);
    rt_ex   = id_use_rt & ex_src  & (id_rt == ex_q.dst);
    rs_mem  = id_use_rs & mem_src & (id_rs == mem_q.dst);
    rt_mem  = id_use_rt & mem_src & (id_rt == mem_q.dst);
  end

  // Hazard, stall and the entry that ID hands to EX (bubble when it cannot advance)
  always_comb begin
`ifdef FORWARD_UNIT_BYPASS_EN
    hazard = ex_q.load & (rs_ex | rt_ex);
`else
    hazard = rs_ex | rt_ex | rs_mem | rt_mem;
`endif
    stall  = ~rst & id_valid & ~flush & hazard;
    bubble = rst | ~id_valid | flush | stall;

    id_entry       = '0;
    id_entry.valid = ~bubble;
    id_entry.wr    = id_reg_write;
    id_entry.load  = id_mem_read;
    id_entry.dst   = id_dst;
  end

  // Next-cycle operand selects; EX result wins over MEM result on a double match
  always_comb begin
    fwd_a_nxt = SEL_RF;
    fwd_b_nxt = SEL_RF;
`ifdef FORWARD_UNIT_BYPASS_EN
    if (!bubble) begin
      if (rs_ex)       fwd_a_nxt = SEL_EXM;
      else if (rs_mem) fwd_a_nxt = SEL_MWB;
      if (rt_ex)       fwd_b_nxt = SEL_EXM;
      else if (rt_mem) fwd_b_nxt = SEL_MWB;
    end
`endif
  end

  // Pipeline tracking and registered selects; reset discards ID and all producers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      ex_q      <= id_entry;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // WB is write-through in the regfile and never matched; MEM load flag is informational
  logic unused_c;
  assign unused_c = ^{wb_q, mem_q.load, ex_q.load};

endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: directed vector table plus a stall-counter saturation sequence.
// Expectations are tabulated for both builds; the active column follows FORWARD_UNIT_BYPASS_EN.
module tb_forward_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 3;
`ifdef FORWARD_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          id_use_rs, id_use_rt;
  logic          id_reg_write, id_mem_read;
  logic          flush;
  logic          stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // sb/ab/bb/cb: bypass build; sn/cn: no-bypass build (selects always 00 there)
  typedef struct {
    int rst, v, rs, rt, urs, urt, dst, wr, ld, fl;
    int sb, sn, ab, bb, cb, cn;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int rst_i, int v, int rs, int rt, int urs, int urt, int dst,
                              int wr, int ld, int fl, int sb, int sn, int ab, int bb,
                              int cb, int cn);
    vec_t r;
    r.rst = rst_i; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.dst = dst; r.wr = wr; r.ld = ld; r.fl = fl;
    r.sb = sb; r.sn = sn; r.ab = ab; r.bb = bb; r.cb = cb; r.cn = cn;
    return r;
  endfunction

  function automatic vec_t idle(int cb, int cn);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cb, cn);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one ID cycle, check comb stall mid-cycle, then the registered outputs after the edge
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    rst          = 1'(v.rst);
    id_valid     = 1'(v.v);
    id_rs        = AW'(v.rs);
    id_rt        = AW'(v.rt);
    id_use_rs    = 1'(v.urs);
    id_use_rt    = 1'(v.urt);
    id_dst       = AW'(v.dst);
    id_reg_write = 1'(v.wr);
    id_mem_read  = 1'(v.ld);
    flush        = 1'(v.fl);
    #1;
    check({nm, " stall"}, int'(stall), BYP ? v.sb : v.sn);
    @(posedge clk);
    #1;
    check({nm, " fwd_a"}, int'(fwd_a_sel), BYP ? v.ab : 0);
    check({nm, " fwd_b"}, int'(fwd_b_sel), BYP ? v.bb : 0);
    check({nm, " cnt"},   int'(stall_cnt), BYP ? v.cb : v.cn);
  endtask

  initial begin
    vec_t v;
    int   ns;
    int   exp_cnt;

    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
    id_use_rt = 1'b0; id_dst = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;

    //              rst v rs rt urs urt dst wr ld fl | sb sn ab bb cb cn
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0)); // reset, ID discarded
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 2, 1, 0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 1, 3, 1, 0, 0,   0, 0, 0, 0, 0, 0)); // add r3
    tbl.push_back(mk(0, 1, 3, 4, 1, 1, 6, 1, 0, 0,   0, 1, 1, 0, 0, 1)); // sub reads r3
    tbl.push_back(idle(0, 1));
    tbl.push_back(idle(0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 1)); // lw r5
    tbl.push_back(mk(0, 1, 1, 5, 1, 1, 8, 1, 0, 0,   1, 1, 0, 0, 1, 2)); // reads rt=r5
    tbl.push_back(mk(0, 1, 1, 5, 1, 1, 8, 1, 0, 0,   0, 1, 0, 2, 1, 3)); // held reader
    tbl.push_back(mk(0, 1, 1, 5, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 1, 3)); // WB match: nothing
    tbl.push_back(idle(1, 3));
    tbl.push_back(idle(1, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 1, 3)); // write r7
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 1, 3)); // write r7 again
    tbl.push_back(mk(0, 1, 7, 7, 1, 1, 9, 1, 0, 0,   0, 1, 1, 1, 1, 4)); // EX beats MEM
    tbl.push_back(idle(1, 4));
    tbl.push_back(idle(1, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 4)); // write r0
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0, 1, 4)); // read r0
    tbl.push_back(idle(1, 4));
    tbl.push_back(idle(1, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 11, 1, 0, 0,  0, 0, 0, 0, 1, 4)); // add r11
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 12, 0, 0, 0,  0, 0, 0, 0, 1, 4)); // non-writer r12
    tbl.push_back(mk(0, 1, 11, 12, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1, 5)); // MEM forward on rs
    tbl.push_back(mk(0, 0, 11, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 5)); // !id_valid
    tbl.push_back(idle(1, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 0,   0, 0, 0, 0, 1, 5)); // lw r4
    tbl.push_back(mk(0, 1, 4, 0, 1, 0, 13, 1, 0, 1,  0, 0, 0, 0, 1, 5)); // flush beats stall
    tbl.push_back(idle(1, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 0,   0, 0, 0, 0, 1, 5)); // lw r4
    tbl.push_back(mk(0, 1, 4, 0, 1, 0, 13, 1, 0, 0,  1, 1, 0, 0, 2, 6)); // stall
    tbl.push_back(mk(1, 1, 4, 0, 1, 0, 13, 1, 0, 0,  0, 0, 0, 0, 0, 0)); // reset mid-stall
    tbl.push_back(mk(0, 1, 4, 0, 1, 0, 13, 1, 0, 0,  0, 0, 0, 0, 0, 0)); // hazard gone
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 0,   0, 0, 0, 0, 0, 0)); // lw r4
    tbl.push_back(mk(1, 1, 4, 0, 1, 0, 13, 1, 0, 0,  0, 0, 0, 0, 0, 0)); // reset masks stall
    tbl.push_back(mk(0, 1, 4, 0, 1, 0, 13, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Repeated load-use pairs drive stall_cnt into saturation at 3'b111
    ns      = BYP ? 1 : 2;
    exp_cnt = 0;
    for (int it = 0; it < 8; it++) begin
      v = mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, exp_cnt, exp_cnt);
      apply(v, $sformatf("sat%0d lw", it));
      for (int k = 0; k <= ns; k++) begin
        if (k < ns) exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
        v = mk(0, 1, 9, 0, 1, 0, 0, 0, 0, 0, (k < ns) ? 1 : 0, (k < ns) ? 1 : 0,
               (k == ns) ? 2 : 0, 0, exp_cnt, exp_cnt);
        apply(v, $sformatf("sat%0d rd%0d", it, k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/forward_unit.md
FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 id_valid  input  1  SHALL mark a real instruction in ID.
REQ-006 id_rs, id_rt  input  REG_ADDR_W each  SHALL carry the ID source-register addresses.
REQ-007 id_use_rs, id_use_rt  input  1 each  SHALL mark that the instruction actually reads rs/rt.
REQ-008 id_dst  input  REG_ADDR_W  SHALL carry the ID destination register.
REQ-009 id_reg_write, id_mem_read  input  1 each  SHALL mark a register write and a load.
REQ-010 flush  input  1  SHALL kill the ID instruction.
REQ-011 stall  output  1  SHALL hold PC and IF/ID when high; combinational.
REQ-012 fwd_a_sel, fwd_b_sel  output  2 each  SHALL be registered 3:1 operand-mux selects for EX: 00 regfile, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
REQ-013 stall_cnt  output  CNT_W  SHALL count stall cycles.

Function
REQ-014 Unit SHALL track three stage entries EX, MEM, WB, each {valid, wr, load, dst}.
REQ-015 Each cycle: WB<=MEM, MEM<=EX; EX<=ID entry, or bubble (valid=0) when stall or flush or !id_valid.
REQ-016 An entry SHALL be a hazard source only if valid & wr & dst!=0.
REQ-017 stall SHALL be 1 iff id_valid & !flush & EX entry is a hazard source with load=1 & (id_use_rs & id_rs==EX.dst | id_use_rt & id_rt==EX.dst).
REQ-018 Next fwd_a_sel SHALL be 01 if id_rs matches EX-entry source, else 10 if it matches MEM-entry source, else 00; fwd_b_sel likewise on id_rt; EX priority over MEM on double match.
REQ-019 Selects SHALL be registered 00 whenever the ID entry becomes a bubble (stall, flush, !id_valid), or the operand is unused.
REQ-020 Selects SHALL be valid in the cycle the instruction occupies EX (latency 1 from ID).
REQ-021 WB-stage matches SHALL produce no forward and no stall; the register file is write-through.
REQ-022 flush SHALL take priority over stall; stall SHALL never last more than one consecutive cycle for one load.
REQ-023 stall_cnt SHALL increment by 1 per cycle stall=1 and saturate at all-ones.

Reset
REQ-024 On rst=1 at a clock edge: EX/MEM/WB valid=0, fwd_a_sel=fwd_b_sel=00, stall_cnt=0.
REQ-025 During the reset cycle stall SHALL evaluate to 0 and the ID instruction SHALL be discarded.
REQ-026 Reset mid-stall SHALL drop the pending hazard; first post-reset cycle stall=0.

Configuration
REQ-027 Macro FORWARD_UNIT_BYPASS_EN defined: behaviour per REQ-017/018.
REQ-028 Macro undefined: fwd selects SHALL be constant 00; stall SHALL be 1 for any id_rs/id_rt match against EX or MEM hazard sources, regardless of load.

Verification
REQ-029 add r3 in ID, next ID sub reads rs=r3 -> fwd_a_sel=01 in sub's EX cycle, stall=0.
REQ-030 lw r5, next instr reads rt=r5 -> stall=1 one cycle, stall_cnt 0->1, then fwd_b_sel=10.
REQ-031 Two writers of r7 back-to-back, third reads r7 on rs and rt -> both selects 01.
REQ-032 Writer to r0 followed by reader of r0 -> selects 00, stall=0.
REQ-033 lw r4 hazard with flush=1 same cycle -> stall=0, EX bubble; rst during stall -> all outputs 00/0 next cycle.
REQ-034 Macro undefined: add r2 then reader of r2 -> stall=1 for 2 cycles, selects 00.
